// File: rtl/pwm_pkg.sv
// Shared register map, control/status bit positions and prescaler encodings
// for the PWM register bank.
package pwm_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_PERIOD = 8'h01;
  localparam logic [7:0] ADDR_DUTY   = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h03;
  localparam logic [7:0] ADDR_COUNT  = 8'h04;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_PSC_LO = 2;
  localparam int CTRL_PSC_HI = 3;

  localparam int STAT_EN   = 0;
  localparam int STAT_PEND = 1;

  localparam logic [1:0] PSC_DIV1 = 2'd0;
  localparam logic [1:0] PSC_DIV2 = 2'd1;
  localparam logic [1:0] PSC_DIV4 = 2'd2;
  localparam logic [1:0] PSC_DIV8 = 2'd3;

  typedef struct packed {
    logic [1:0] psc;
    logic       inv;
    logic       en;
  } ctrl_t;

  // Low prescaler bits that must all be ones for a tick.
  function automatic logic [2:0] psc_mask(input logic [1:0] psc);
    logic [2:0] m;
    case (psc)
      PSC_DIV1: m = 3'b000;
      PSC_DIV2: m = 3'b001;
      PSC_DIV4: m = 3'b011;
      default:  m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM engine: prescaler, period counter, active period/duty registers and the
// registered output. Shadow values come in from the register bank.
module pwm_core
  import pwm_pkg::*;
#(
  parameter logic [7:0] RST_PERIOD = 8'hFF,
  parameter logic [7:0] RST_DUTY   = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inv,
  input  logic [1:0] psc,
  input  logic       load,
  input  logic [7:0] period_sh,
  input  logic [7:0] duty_sh,
  output logic [7:0] cnt,
  output logic       wrap,
  output logic       pwm_out
);

  logic [2:0] pre;
  logic [7:0] period_act;
  logic [7:0] duty_act;
  logic [2:0] mask;
  logic       tick;

  assign mask = psc_mask(psc);
  assign tick = en && ((pre & mask) == mask);
  assign wrap = tick && (cnt == period_act);

  // Prescaler, counter, active-register reload and output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= 3'd0;
      cnt        <= 8'd0;
      period_act <= RST_PERIOD;
      duty_act   <= RST_DUTY;
      pwm_out    <= 1'b0;
    end else begin
      // load only fires while disabled, so it never races a wrap
      if (load) begin
        cnt        <= 8'd0;
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end else if (!en) begin
        cnt <= 8'd0;
      end else if (wrap) begin
        cnt        <= 8'd0;
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end else if (tick) begin
        cnt <= cnt + 8'd1;
      end
      pre     <= en ? pre + 3'd1 : 3'd0;
      pwm_out <= en ? ((cnt < duty_act) ^ inv) : 1'b0;
    end
  end

endmodule

// File: rtl/pwm_regbank.sv
// SPI-facing register bank for a single PWM channel: CTRL, shadowed
// PERIOD/DUTY, STATUS and COUNT. The PWM engine lives in pwm_core.
module pwm_regbank
  import pwm_pkg::*;
#(
  parameter logic [7:0] RST_PERIOD = 8'hFF,
  parameter logic [7:0] RST_DUTY   = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] data_wr,
  input  logic       wr_en,
  output logic [7:0] data_rd,
  output logic       pwm_out
);

  ctrl_t      ctrl;
  logic [7:0] period_sh;
  logic [7:0] duty_sh;
  logic       pend;
  logic [7:0] cnt;
  logic       wrap;
  logic       wr_ctrl, wr_period, wr_duty, load;

  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign wr_period = wr_en && (addr == ADDR_PERIOD);
  assign wr_duty   = wr_en && (addr == ADDR_DUTY);
  // enable rising edge restarts the period with fresh active values
  assign load      = wr_ctrl && data_wr[CTRL_EN] && !ctrl.en;

  // Control, shadow registers and pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      period_sh <= RST_PERIOD;
      duty_sh   <= RST_DUTY;
      pend      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl.en  <= data_wr[CTRL_EN];
        ctrl.inv <= data_wr[CTRL_INV];
        ctrl.psc <= data_wr[CTRL_PSC_HI:CTRL_PSC_LO];
      end
      if (wr_period) period_sh <= data_wr;
      if (wr_duty)   duty_sh   <= data_wr;
      // a shadow write in a wrap cycle keeps PEND: its value missed the reload
      if (wr_period || wr_duty) pend <= 1'b1;
      else if (wrap || load)    pend <= 1'b0;
    end
  end

  // Read decode.
  always_comb begin
    data_rd = 8'h00;
    case (addr)
      ADDR_CTRL:   data_rd = {4'b0000, ctrl.psc, ctrl.inv, ctrl.en};
      ADDR_PERIOD: data_rd = period_sh;
      ADDR_DUTY:   data_rd = duty_sh;
      ADDR_STATUS: begin
        data_rd[STAT_EN]   = ctrl.en;
        data_rd[STAT_PEND] = pend;
      end
      ADDR_COUNT:  data_rd = cnt;
      default:     data_rd = 8'h00;
    endcase
  end

  pwm_core #(
    .RST_PERIOD(RST_PERIOD),
    .RST_DUTY  (RST_DUTY)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl.en),
    .inv      (ctrl.inv),
    .psc      (ctrl.psc),
    .load     (load),
    .period_sh(period_sh),
    .duty_sh  (duty_sh),
    .cnt      (cnt),
    .wrap     (wrap),
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_pwm_regbank.sv
// Bench for pwm_regbank: directed scenarios plus random register traffic,
// all checked every cycle against a behavioural model of the PWM channel.
module tb_pwm_regbank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_wr = 8'h00;
  logic       wr_en = 1'b0;
  logic [7:0] data_rd;
  logic       pwm_out;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_en = 0, m_inv = 0, m_psc = 0;
  int m_psh = 255, m_dsh = 128, m_pact = 255, m_dact = 128;
  int m_cnt = 0, m_pre = 0, m_pend = 0, m_pwm = 0;

  always #5 clk = ~clk;

  pwm_regbank #(.RST_PERIOD(8'hFF), .RST_DUTY(8'h80)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .data_wr(data_wr),
    .wr_en  (wr_en),
    .data_rd(data_rd),
    .pwm_out(pwm_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [7:0] a);
    case (a)
      8'd0: return 8'(m_en + 2 * m_inv + 4 * m_psc);
      8'd1: return 8'(m_psh);
      8'd2: return 8'(m_dsh);
      8'd3: return 8'(m_en + 2 * m_pend);
      8'd4: return 8'(m_cnt);
      default: return 8'h00;
    endcase
  endfunction

  // One clock of the channel, computed from the inputs present at the edge.
  task automatic m_step();
    int div, tick, wrap, ld, shw;
    if (rst) begin
      m_en = 0; m_inv = 0; m_psc = 0;
      m_psh = 255; m_dsh = 128; m_pact = 255; m_dact = 128;
      m_cnt = 0; m_pre = 0; m_pend = 0; m_pwm = 0;
    end else begin
      div  = 1 << m_psc;
      tick = (m_en != 0) && ((m_pre % div) == div - 1);
      wrap = tick && (m_cnt == m_pact);
      ld   = wr_en && addr == 8'd0 && data_wr[0] && (m_en == 0);
      shw  = wr_en && (addr == 8'd1 || addr == 8'd2);
      m_pwm = (m_en != 0) ? (((m_cnt < m_dact) ? 1 : 0) ^ m_inv) : 0;
      if (ld || wrap) begin
        m_cnt = 0; m_pact = m_psh; m_dact = m_dsh;
      end else if (m_en == 0) m_cnt = 0;
      else if (tick) m_cnt = m_cnt + 1;
      m_pre  = (m_en != 0) ? (m_pre + 1) % 8 : 0;
      m_pend = shw ? 1 : ((wrap || ld) ? 0 : m_pend);
      if (wr_en) begin
        case (addr)
          8'd0: begin m_en = int'(data_wr[0]); m_inv = int'(data_wr[1]); m_psc = int'(data_wr[3:2]); end
          8'd1: m_psh = int'(data_wr);
          8'd2: m_dsh = int'(data_wr);
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    logic [7:0] save;
    @(posedge clk);
    m_step();
    #1;
    chk("pwm_out", {7'd0, pwm_out}, 8'(m_pwm));
    chk("rd_addr", data_rd, m_rd(addr));
    save = addr;
    addr = 8'd3; #1; chk("status", data_rd, m_rd(8'd3));
    addr = 8'd4; #1; chk("count", data_rd, m_rd(8'd4));
    addr = save;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_wr = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd_const(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] save;
    save = addr; addr = a; #1;
    chk(tag, data_rd, exp);
    addr = save;
  endtask

  task automatic count_high(input string tag, input int n, input int exp);
    int highs;
    highs = 0;
    repeat (n) begin step(); highs += int'(pwm_out); end
    chk(tag, 8'(highs), 8'(exp));
  endtask

  // Advance until COUNT reads t (bounded); expiry shows as a failed check.
  task automatic wait_cnt(input string tag, input int t);
    int n;
    n = 0;
    while (m_cnt != t && n < 300) begin step(); n++; end
    rd_const(tag, 8'd4, 8'(t));
  endtask

  initial begin
    int bp[3], bd[3], bh[3];
    bp = '{9, 9, 0}; bd = '{0, 10, 1}; bh = '{0, 20, 20};

    // reset state
    rst = 1'b1; step(); step(); rst = 1'b0;
    rd_const("rst_period", 8'd1, 8'hFF);
    rd_const("rst_duty", 8'd2, 8'h80);
    rd_const("rst_status", 8'd3, 8'h00);
    chk("rst_pwm", {7'd0, pwm_out}, 8'd0);

    // basic 3/10 waveform
    wr(8'd1, 8'd9); wr(8'd2, 8'd3); wr(8'd0, 8'h01);
    idle(2);
    count_high("p9d3_highs", 20, 6);

    // duty change mid-period is deferred to the next period
    wait_cnt("wait_cnt4", 4);
    wr(8'd2, 8'd6);
    rd_const("pend_set", 8'd3, 8'h03);
    wait_cnt("wait_wrap", 0);
    rd_const("pend_clr", 8'd3, 8'h01);
    idle(2);
    count_high("p9d6_highs", 20, 12);

    // inverted, divide by 4
    wr(8'd0, 8'h00); wr(8'd1, 8'd1); wr(8'd2, 8'd1); wr(8'd0, 8'h0B);
    idle(3);
    count_high("psc4_inv_highs", 16, 8);

    // boundary duty/period cases
    for (int i = 0; i < 3; i++) begin
      wr(8'd0, 8'h00); wr(8'd1, 8'(bp[i])); wr(8'd2, 8'(bd[i])); wr(8'd0, 8'h01);
      idle(2);
      count_high("boundary_highs", 20, bh[i]);
    end

    // disable mid-period
    wr(8'd0, 8'h00); wr(8'd1, 8'd9); wr(8'd2, 8'd3); wr(8'd0, 8'h01);
    idle(5);
    wr(8'd0, 8'h00);
    step();
    chk("dis_pwm", {7'd0, pwm_out}, 8'd0);
    rd_const("dis_count", 8'd4, 8'h00);

    // held PERIOD write coincident with a wrap
    wr(8'd0, 8'h01);
    wait_cnt("wait_cnt9", 9);
    addr = 8'd1; data_wr = 8'd5; wr_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 7) rd_const("old_period_kept", 8'd4, 8'd6);
    end
    wr_en = 1'b0;
    rd_const("held_pend", 8'd3, 8'h03);
    idle(3);

    // reset mid-period beats a simultaneous write
    rst = 1'b1; wr_en = 1'b1; addr = 8'd2; data_wr = 8'h11;
    step();
    rst = 1'b0; wr_en = 1'b0;
    rd_const("rst2_period", 8'd1, 8'hFF);
    rd_const("rst2_duty", 8'd2, 8'h80);
    rd_const("rst2_status", 8'd3, 8'h00);
    rd_const("rst2_ctrl", 8'd0, 8'h00);
    rd_const("rst2_count", 8'd4, 8'h00);
    chk("rst2_pwm", {7'd0, pwm_out}, 8'd0);

    // random register traffic
    repeat (400) begin
      rst     = ($urandom_range(0, 99) < 2);
      wr_en   = ($urandom_range(0, 99) < 30);
      addr    = 8'($urandom_range(0, 7));
      data_wr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_regbank.md
PWM_REGBANK -- requirements
Module: pwm_regbank

Interface
REQ-001 Parameter: RST_PERIOD, 8'hFF, reset value of the PERIOD shadow and active registers.
REQ-002 Parameter: RST_DUTY, 8'h80, reset value of the DUTY shadow and active registers.
REQ-003 Port: clk  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: addr  input  8  register address from the SPI slave; bit 7 is always 0.
REQ-006 Port: data_wr  input  8  write data from the SPI slave.
REQ-007 Port: wr_en  input  1  write strobe; level, may stay high for many consecutive cycles.
REQ-008 Port: data_rd  output  8  read data for the SPI slave; combinational decode of addr.
REQ-009 Port: pwm_out  output  1  registered PWM output.

Function
REQ-010 Register map: 0x00 CTRL (RW), 0x01 PERIOD (RW, shadow), 0x02 DUTY (RW, shadow), 0x03 STATUS (RO), 0x04 COUNT (RO); other addresses read 0, and writes to them are ignored.
REQ-011 CTRL: bit0 EN; bit1 INV; bits[3:2] PSC (divide by 1/2/4/8); bits[7:4] read 0.
REQ-012 STATUS: bit0 EN; bit1 PEND (shadow not yet applied); bits[7:2] read 0.
REQ-013 Every cycle with wr_en=1 writes the addressed register; repeated writes of the same value are idempotent.
REQ-014 A write to PERIOD or DUTY updates the shadow register only and sets PEND.
REQ-015 Prescaler: 3-bit free-running counter; tick=1 when its low PSC bits are all ones; PSC=0 gives a tick every cycle; the counter is held at 0 while EN=0.
REQ-016 Counter cnt (8-bit): on a tick, if cnt==period_act then cnt<=0, else cnt<=cnt+1.
REQ-017 On a tick with cnt==period_act (wrap), active registers are loaded from the shadows and PEND is cleared.
REQ-018 If a shadow write and a wrap occur in the same cycle, the active register takes the pre-write shadow value and PEND stays set.
REQ-019 On an EN 0->1 write: cnt<=0, active registers are loaded from the shadows, and PEND is cleared.
REQ-020 While EN=0: cnt is held at 0, and pwm_out=0 regardless of INV.
REQ-021 While EN=1: pwm_out <= (cnt < duty_act) XOR INV, registered, so it lags cnt by one cycle.
REQ-022 Boundaries: duty_act=0 gives a constant low raw output; duty_act>period_act gives a constant high raw output; period_act=0 keeps cnt at 0 and the output high iff duty_act>0.
REQ-023 Period length = (period_act+1) x 2^PSC clk cycles.
REQ-024 Reads return the shadow values for PERIOD and DUTY, and the live cnt for COUNT.

Reset
REQ-025 rst=1 sets: CTRL=0, PERIOD shadow and active = RST_PERIOD, DUTY shadow and active = RST_DUTY, cnt=0, prescaler=0, PEND=0, pwm_out=0.
REQ-026 rst takes priority over wr_en in the same cycle, and a reset mid-period discards any pending shadow update.

Structure
REQ-027 Register addresses, CTRL/STATUS bit positions and PSC encodings shall be localparams in the shared package pwm_pkg.
REQ-028 One sub-module, pwm_core, shall hold the prescaler, cnt, active registers and output flop; the register decode stays in pwm_regbank.

Verification
REQ-029 Reset, then read 0x01/0x02/0x03 -> 0xFF/0x80/0x00; pwm_out=0.
REQ-030 Write PERIOD=9, DUTY=3, CTRL=0x01 -> pwm_out high 3 cycles, low 7 cycles, repeating with period 10.
REQ-031 Running at P=9/D=3, write DUTY=6 at cnt=4 -> STATUS=0x03 until the next wrap, then 0x01; the new duty takes effect from the next period only.
REQ-032 CTRL=0x0B (EN, INV, PSC=2), P=1, D=1 -> period of 8 cycles, low 4 / high 4.
REQ-033 DUTY=0 gives constant 0; DUTY=10 with P=9 gives constant 1; P=0 with D=1 gives constant 1; writing CTRL=0 mid-period gives pwm_out=0 next cycle and COUNT reads 0.
REQ-034 Hold wr_en=1 for 20 cycles on PERIOD=5 coincident with a wrap -> active period stays old for that period and becomes 5 after the next wrap; assert rst mid-period -> all values per REQ-025.
